multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Sequences the shared multi-cycle mult/div unit for the execute stage. Issues one start pulse
//  per mul/div instruction held in DX and stalls PC/FD/DX until the unit finishes. Then
//  presents the result and an rstatus exception code to the XM latch for one cycle.
//  Sits between the pipeline control decoder (assert_mult/assert_div) and the multdiv unit.
// PARAMETERS
//  WIDTH      32  operand/result width
//  MAX_LAT    40  timeout limit in BUSY cycles (used only with MULTDIV_TIMEOUT_EN)
//  RS_MULT    4   rstatus code for mult exception
//  RS_DIV     5   rstatus code for div exception
// PORTS
//  clock          in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-high
//  assert_mult    in   1      DX holds a mult instruction
//  assert_div     in   1      DX holds a div instruction
//  flush          in   1      taken branch/jump squashes DX this cycle
//  op_a, op_b     in   WIDTH  bypassed ALU operands from DX
//  unit_result    in   WIDTH  multdiv data_result
//  unit_ready     in   1      multdiv data_resultRDY (single-cycle pulse)
//  unit_exception in   1      multdiv data_exception, valid with unit_ready
//  ctrl_MULT      out  1      one-cycle start pulse to the unit
//  ctrl_DIV       out  1      one-cycle start pulse to the unit
//  unit_a, unit_b out  WIDTH  latched operands, stable from issue until DONE
//  md_stall       out  1      freeze PC, FD and DX latches
//  md_valid       out  1      md_result is valid for XM capture
//  md_result      out  WIDTH  captured result
//  md_exc         out  1      exception flag for the completed op
//  md_rstatus     out  WIDTH  RS_MULT/RS_DIV when md_exc is set, else 0
// BEHAVIOUR
//  - Reset (async): state=IDLE, count=0, every output 0, operand/result registers 0.
//  - FSM: IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
//  - IDLE: md_stall = (assert_mult|assert_div) & ~flush, combinational. If that term is set,
//    latch op_a/op_b and op kind (mult wins if both are asserted) on the edge, then go to ISSUE.
//  - ISSUE (1 cycle): ctrl_MULT or ctrl_DIV=1, md_stall=1, count cleared. Next state is BUSY.
//  - BUSY: md_stall=1, count+=1 per cycle (saturating). On unit_ready, capture unit_result and
//    unit_exception, then go to DONE.
//  - DONE (1 cycle): md_stall=0, md_valid=1, md_result/md_exc/md_rstatus held.
//    assert_* are ignored here because the same instruction is still in DX. Next state is IDLE.
//  - Issue latency: start pulse 1 cycle after the DX op is seen. Total stall = 2 + unit latency.
//  - flush in ISSUE or BUSY: abort to IDLE next cycle, md_stall=0, no md_valid. Any later
//    unit_ready is ignored.
//  - unit_ready in IDLE, ISSUE or DONE: ignored.
//  - md_rstatus = md_exc ? (op==mult ? RS_MULT : RS_DIV) : 0. Zero-extended to WIDTH.
//  - md_result forced to 0 when md_exc is set by timeout. A unit exception passes unit_result through.
//  - Outputs ctrl_*, md_valid, md_result, md_exc and md_rstatus are registered.
//    md_stall is combinational in IDLE only.
// CONFIGURATION
//  MULTDIV_TIMEOUT_EN defined:
//    - In BUSY, count reaching MAX_LAT without unit_ready forces DONE with md_exc=1 and md_result=0.
//  MULTDIV_TIMEOUT_EN undefined:
//    - No timeout logic. BUSY waits indefinitely for unit_ready. count is only used for the flush clear.
// TESTING
//  - Reset: assert reset mid-BUSY (cycle 5) -> all outputs 0 next sample, no ctrl pulse, state IDLE.
//  - mult 7*6: assert_mult, unit_ready 33 cycles after ctrl_MULT ->
//      ctrl_MULT pulses once;
//      md_stall high for ISSUE + all BUSY cycles;
//      DONE: md_valid=1, md_result=42, md_rstatus=0.
//  - div by zero: assert_div, op_b=0, unit_ready+unit_exception -> md_exc=1, md_rstatus=5;
//      assert_div still high in DONE -> no second ctrl_DIV.
//  - Flush: assert_mult with flush high same cycle -> no stall, no pulse;
//      flush in BUSY cycle 3 -> IDLE, md_valid never asserted, stray unit_ready ignored.
//  - Back-to-back: mult then div in consecutive DX slots -> div issues 1 cycle after DONE,
//      op_a/op_b captured fresh, exactly one pulse each.
//  - MULTDIV_TIMEOUT_EN, MAX_LAT=40, unit_ready never arrives -> DONE after 40 BUSY cycles,
//      md_exc=1, md_result=0, md_rstatus=4 for mult.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer
//
// Sequences the shared multi-cycle mult/div unit for the execute stage.
// A mul/div instruction in DX triggers one start pulse to the unit. PC/FD/DX
// stay frozen until the unit reports completion. The result and an rstatus
// exception code are then presented to the XM latch for exactly one cycle.
//
// State flow: IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
// A flush in ISSUE or BUSY aborts the operation back to IDLE.
//
// Optional feature (compile-time macro MULTDIV_TIMEOUT_EN):
//   When defined, BUSY gives up after MAX_LAT cycles without unit_ready.
//   It then completes with md_exc=1 and md_result=0.
//   When undefined, BUSY waits for unit_ready indefinitely.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   assert_mult/assert_div  DX holds a mult/div instruction
//   flush                   taken branch/jump squashes DX this cycle
//   op_a, op_b              bypassed operands from DX
//   unit_result/ready/exc   completion interface of the multdiv unit
//   ctrl_MULT/ctrl_DIV      registered one-cycle start pulses to the unit
//   unit_a, unit_b          operands latched at issue, stable until DONE
//   md_stall                freeze PC/FD/DX (combinational in IDLE only)
//   md_valid                one-cycle strobe for XM capture
//   md_result/exc/rstatus   registered completion data, held until the next op
// ---------------------------------------------------------------------------
module multdiv_sequencer #(
    parameter int WIDTH   = 32,
    parameter int MAX_LAT = 40,
    parameter int RS_MULT = 4,
    parameter int RS_DIV  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             assert_mult,
    input  logic             assert_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] unit_result,
    input  logic             unit_ready,
    input  logic             unit_exception,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    output logic             md_stall,
    output logic             md_valid,
    output logic [WIDTH-1:0] md_result,
    output logic             md_exc,
    output logic [WIDTH-1:0] md_rstatus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int CW = $clog2(MAX_LAT + 1);

`ifdef MULTDIV_TIMEOUT_EN
    // count is 0 in the first BUSY cycle, so MAX_LAT-1 marks the last allowed one
    localparam logic [CW-1:0] LAT_LIM = CW'(MAX_LAT - 1);
`endif

    // Exception code for the completed op, zero when there is no exception
    function automatic logic [WIDTH-1:0] rs_code(input logic is_mult, input logic exc);
        logic [WIDTH-1:0] code;
        if (!exc) begin
            code = {WIDTH{1'b0}};
        end else if (is_mult) begin
            code = WIDTH'(RS_MULT);
        end else begin
            code = WIDTH'(RS_DIV);
        end
        return code;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             op_mult_q, op_mult_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             ctrl_mult_q, ctrl_mult_d;
    logic             ctrl_div_q, ctrl_div_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic [WIDTH-1:0] rstatus_q, rstatus_d;
    logic             req_s;
    logic             stall_s;
    logic             timeout_s;

    assign req_s = (assert_mult | assert_div) & ~flush;

    // Next-state, datapath capture and stall decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        op_mult_d   = op_mult_q;
        a_d         = a_q;
        b_d         = b_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        valid_d     = 1'b0;
        result_d    = result_q;
        exc_d       = exc_q;
        rstatus_d   = rstatus_q;
        stall_s     = 1'b0;
        timeout_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Stall must reach PC/FD/DX in the same cycle the op is seen
                stall_s = req_s;
                if (req_s) begin
                    a_d         = op_a;
                    b_d         = op_b;
                    op_mult_d   = assert_mult;
                    ctrl_mult_d = assert_mult;
                    ctrl_div_d  = ~assert_mult;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                stall_s = 1'b1;
                count_d = {CW{1'b0}};
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                if (count_q != {CW{1'b1}}) begin
                    count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    count_d = count_q;
                end
`ifdef MULTDIV_TIMEOUT_EN
                timeout_s = (count_q >= LAT_LIM);
`else
                timeout_s = 1'b0;
`endif
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (unit_ready) begin
                    result_d  = unit_result;
                    exc_d     = unit_exception;
                    rstatus_d = rs_code(op_mult_q, unit_exception);
                    valid_d   = 1'b1;
                    state_d   = ST_DONE;
                end else if (timeout_s) begin
                    result_d  = {WIDTH{1'b0}};
                    exc_d     = 1'b1;
                    rstatus_d = rs_code(op_mult_q, 1'b1);
                    valid_d   = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                // The completed instruction is still in DX, so assert_* is ignored here
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= {CW{1'b0}};
            op_mult_q   <= 1'b0;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            exc_q       <= 1'b0;
            rstatus_q   <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op_mult_q   <= op_mult_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            exc_q       <= exc_d;
            rstatus_q   <= rstatus_d;
        end
    end

    assign ctrl_MULT  = ctrl_mult_q;
    assign ctrl_DIV   = ctrl_div_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign md_stall   = stall_s;
    assign md_valid   = valid_q;
    assign md_result  = result_q;
    assign md_exc     = exc_q;
    assign md_rstatus = rstatus_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multdiv_sequencer
//
// Directed bench for multdiv_sequencer. The bench plays the role of the
// multdiv unit by driving unit_ready/unit_result directly.
// Inputs change 1 time unit after the rising edge.
// Outputs are checked 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_multdiv_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         assert_mult = 1'b0;
    logic         assert_div = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] op_a = 32'd0;
    logic [W-1:0] op_b = 32'd0;
    logic [W-1:0] unit_result = 32'd0;
    logic         unit_ready = 1'b0;
    logic         unit_exception = 1'b0;
    logic         ctrl_MULT, ctrl_DIV;
    logic [W-1:0] unit_a, unit_b;
    logic         md_stall, md_valid, md_exc;
    logic [W-1:0] md_result, md_rstatus;

    int n_checks = 0;
    int n_errs   = 0;
    int n_mult   = 0;
    int n_div    = 0;

    multdiv_sequencer #(.WIDTH(32), .MAX_LAT(40), .RS_MULT(4), .RS_DIV(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .assert_mult    (assert_mult),
        .assert_div     (assert_div),
        .flush          (flush),
        .op_a           (op_a),
        .op_b           (op_b),
        .unit_result    (unit_result),
        .unit_ready     (unit_ready),
        .unit_exception (unit_exception),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .unit_a         (unit_a),
        .unit_b         (unit_b),
        .md_stall       (md_stall),
        .md_valid       (md_valid),
        .md_result      (md_result),
        .md_exc         (md_exc),
        .md_rstatus     (md_rstatus)
    );

    // 10-unit clock
    always #5 clock = ~clock;

    // Count start pulses away from the active edge
    always @(negedge clock) begin
        if (ctrl_MULT) n_mult++;
        if (ctrl_DIV)  n_div++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_ctrl_mult"}, {31'd0, ctrl_MULT}, 32'd0);
        check_val({tag, "_ctrl_div"},  {31'd0, ctrl_DIV},  32'd0);
        check_val({tag, "_valid"},     {31'd0, md_valid},  32'd0);
    endtask

    // One idle DX slot: no request, no pulse, no valid
    task automatic idle_cycle(input string tag);
        next_cycle();
        assert_mult = 1'b0; assert_div = 1'b0; flush = 1'b0;
        unit_ready = 1'b0; unit_exception = 1'b0;
        settle();
        check_quiet(tag);
        check_val({tag, "_stall"}, {31'd0, md_stall}, 32'd0);
    endtask

    // Full operation: DX op seen, ISSUE, lat BUSY cycles, DONE.
    // It returns in the DONE cycle with assert_* still high.
    task automatic run_op(input string tag, input bit is_mult, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] res,
                          input bit exc, input bit no_ready);
        int m0, d0;
        logic [31:0] exp_res, exp_rs;
        bit exp_exc;
        exp_exc = exc | no_ready;
        exp_res = no_ready ? 32'd0 : res;
        exp_rs  = exp_exc ? (is_mult ? 32'd4 : 32'd5) : 32'd0;

        next_cycle();
        assert_mult = is_mult; assert_div = !is_mult; op_a = a; op_b = b;
        flush = 1'b0; unit_ready = 1'b0; unit_exception = 1'b0;
        settle();
        check_val({tag, "_idle_stall"}, {31'd0, md_stall}, 32'd1);
        check_val({tag, "_idle_noctrl"}, {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        m0 = n_mult; d0 = n_div;

        next_cycle();
        settle();
        check_val({tag, "_issue_mult"}, {31'd0, ctrl_MULT}, {31'd0, is_mult});
        check_val({tag, "_issue_div"},  {31'd0, ctrl_DIV},  {31'd0, !is_mult});
        check_val({tag, "_unit_a"}, unit_a, a);
        check_val({tag, "_unit_b"}, unit_b, b);
        check_val({tag, "_issue_stall"}, {31'd0, md_stall}, 32'd1);

        for (int i = 1; i <= lat; i++) begin
            next_cycle();
            unit_ready     = (i == lat) && !no_ready;
            unit_result    = (i == lat) ? res : 32'h0;
            unit_exception = (i == lat) && exc;
            settle();
            check_val({tag, "_busy_stall"}, {31'd0, md_stall}, 32'd1);
            check_val({tag, "_busy_valid"}, {31'd0, md_valid}, 32'd0);
        end

        next_cycle();
        unit_ready = 1'b0; unit_exception = 1'b0; unit_result = 32'h0;
        settle();
        check_val({tag, "_done_valid"},   {31'd0, md_valid}, 32'd1);
        check_val({tag, "_done_result"},  md_result, exp_res);
        check_val({tag, "_done_exc"},     {31'd0, md_exc}, {31'd0, exp_exc});
        check_val({tag, "_done_rstatus"}, md_rstatus, exp_rs);
        check_val({tag, "_done_stall"},   {31'd0, md_stall}, 32'd0);
        check_val({tag, "_mult_pulses"},  n_mult - m0, {31'd0, is_mult});
        check_val({tag, "_div_pulses"},   n_div - d0,  {31'd0, !is_mult});
    endtask

    initial begin
        // Reset state
        #2;
        check_val("rst_ctrl",    {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        check_val("rst_stall",   {31'd0, md_stall}, 32'd0);
        check_val("rst_valid",   {31'd0, md_valid}, 32'd0);
        check_val("rst_result",  md_result, 32'd0);
        check_val("rst_rstatus", md_rstatus, 32'd0);
        check_val("rst_unit_a",  unit_a, 32'd0);
        next_cycle();
        reset = 1'b0;
        idle_cycle("post_rst");

        // mult 7*6 with unit latency 33
        run_op("mul76", 1'b1, 32'd7, 32'd6, 33, 32'd42, 1'b0, 1'b0);
        idle_cycle("mul76_after");

        // div by zero with a unit exception, assert_div held through DONE
        run_op("div0", 1'b0, 32'd100, 32'd0, 3, 32'hDEAD_BEEF, 1'b1, 1'b0);
        idle_cycle("div0_after");

        // Back-to-back: mult then div in consecutive DX slots
        run_op("b2b_mul", 1'b1, 32'd3, 32'd5, 2, 32'd15, 1'b0, 1'b0);
        run_op("b2b_div", 1'b0, 32'd20, 32'd4, 1, 32'd5, 1'b0, 1'b0);
        idle_cycle("b2b_after");

        // Flush in the same cycle as the request: no stall, no pulse
        next_cycle();
        assert_mult = 1'b1; flush = 1'b1; op_a = 32'd9; op_b = 32'd9;
        settle();
        check_val("flush0_stall", {31'd0, md_stall}, 32'd0);
        idle_cycle("flush0_next");

        // Flush in BUSY cycle 3, then a stray unit_ready
        next_cycle();
        assert_mult = 1'b1; flush = 1'b0; op_a = 32'd11; op_b = 32'd12;
        next_cycle();
        settle();
        check_val("flushb_issue", {31'd0, ctrl_MULT}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            flush = (i == 3);
        end
        next_cycle();
        assert_mult = 1'b0; flush = 1'b0; unit_ready = 1'b1; unit_result = 32'd132;
        settle();
        check_val("flushb_stall", {31'd0, md_stall}, 32'd0);
        check_quiet("flushb_idle");
        next_cycle();
        unit_ready = 1'b0;
        settle();
        check_quiet("flushb_stray");
        check_val("flushb_result_held", md_result, 32'd5);

        // Reset asserted in BUSY cycle 5
        next_cycle();
        assert_mult = 1'b1; op_a = 32'd13; op_b = 32'd14;
        for (int i = 0; i < 6; i++) next_cycle();
        settle();
        check_val("rstb_busy_stall", {31'd0, md_stall}, 32'd1);
        assert_mult = 1'b0;
        reset = 1'b1;
        settle();
        check_val("rstb_ctrl",    {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        check_val("rstb_stall",   {31'd0, md_stall}, 32'd0);
        check_val("rstb_valid",   {31'd0, md_valid}, 32'd0);
        check_val("rstb_result",  md_result, 32'd0);
        check_val("rstb_unit_a",  unit_a, 32'd0);
        next_cycle();
        reset = 1'b0;
        idle_cycle("rstb_idle");
        next_cycle();
        unit_ready = 1'b1; unit_result = 32'd182;
        settle();
        check_quiet("rstb_stray");
        unit_ready = 1'b0;

        // Fresh op after reset
        run_op("mul99", 1'b1, 32'd9, 32'd9, 4, 32'd81, 1'b0, 1'b0);
        idle_cycle("mul99_after");

`ifdef MULTDIV_TIMEOUT_EN
        // unit_ready never arrives: DONE after 40 BUSY cycles
        run_op("tmo", 1'b1, 32'd1, 32'd2, 40, 32'd0, 1'b0, 1'b1);
        idle_cycle("tmo_after");
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
